alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Writeback stage directly downstream of the 6-bit ALU.
- Captures each ALU result into a 4-entry register file and latches the zero flag.
- Counts retired results and streams every committed result, tagged with its destination, to an output/display port through a 2-entry FIFO with valid/ready backpressure.
- Register-file read ports feed operand selection back toward the ALU, with same-cycle write forwarding.

Parameters:
- DATA_W, 6, datapath width of results and registers
- REG_N, 4, number of architectural registers
- ADDR_W, 2, register address width (log2 REG_N)
- CNT_W, 8, width of the retire counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- res_valid  in  1  ALU result valid this cycle
- res_ready  out  1  stage can accept a result
- res_data  in  DATA_W  ALU result
- res_zf  in  1  ALU zero flag (1 = result is zero), stored as presented
- res_dst  in  ADDR_W  destination register index
- flush  in  1  synchronous flush of the output FIFO
- rd_addr_a  in  ADDR_W  read port A address
- rd_data_a  out  DATA_W  read port A data (combinational)
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_b  out  DATA_W  read port B data (combinational)
- flag_zero_q  out  1  registered zero flag of last accepted result
- retire_cnt  out  CNT_W  number of accepted results, modulo 2^CNT_W
- out_valid  out  1  output FIFO head valid
- out_ready  in  1  downstream consumes head
- out_dst  out  ADDR_W  destination tag of head entry
- out_data  out  DATA_W  data of head entry

Behaviour:
- Reset (async, on reset=1 immediately):
  - all registers = 0; flag_zero_q = 0; retire_cnt = 0
  - FIFO count and pointers = 0, so out_valid = 0; out_dst/out_data = 0
  - res_ready = 1 once reset deasserts
- Accept = res_valid & res_ready. On the rising edge where accept = 1:
  - regs[res_dst] <= res_data
  - flag_zero_q <= res_zf
  - retire_cnt <= retire_cnt + 1, wrapping 255 -> 0
  - push {res_dst, res_data} into the FIFO
- res_ready = ~flush & (fifo_count != 2).
  - Comes only from registered count and flush; no combinational path from out_ready.
  - A full FIFO with a pop in the same cycle still reports not-ready.
- Without accept, registers, flag and counter hold.
- Read ports are combinational.
  - If accept = 1 and rd_addr_x == res_dst, rd_data_x = res_data (forwarding).
  - Otherwise rd_data_x = regs[rd_addr_x].
  - Both ports may read the same address.
- Output FIFO, 2 entries, no fall-through:
  - out_valid = (count != 0); out_dst/out_data show the head entry.
  - Pop = out_valid & out_ready.
  - Push into an empty FIFO: out_valid rises the cycle after accept (latency 1).
  - Push and pop at count 1: count stays 1 and the head becomes the new entry.
  - Pop at count 2: count -> 1; res_ready rises the next cycle.
  - Pointers are 1 bit each and wrap naturally.
  - out_data holds while out_valid & ~out_ready; it must not change until popped.
- flush = 1 at an edge:
  - count and pointers -> 0, so out_valid = 0 next cycle
  - res_ready = 0 in that cycle, so nothing is accepted
  - register file, flag and retire_cnt are untouched
- Reset asserted mid-transfer discards the in-flight accept and all FIFO contents.

Decomposition:
- Shared package cpu6_pkg holds:
  - DATA_W = 6, ADDR_W = 2, REG_N = 4
  - opcode encodings shared with the controller and ALU
  - typedef wb_entry_t = {dst, data}
- One sub-module, wb_out_fifo: 2-entry synchronous FIFO with count, flush, push/pop, async reset.
- The register file, forwarding, flag and counter stay in alu_writeback.

Test Plan:
- Reset then idle:
  - required: rd_data_a/b = 0, flag_zero_q = 0, retire_cnt = 0, out_valid = 0, res_ready = 1.
- Single write, read back and drain:
  - stimulus: res_valid=1, res_dst=2, res_data=6'h2A, res_zf=0, with out_ready=1 throughout.
  - required in the accept cycle, rd_addr_a=2: rd_data_a = 2A via forwarding.
  - required after the edge: regs[2] = 2A, retire_cnt = 1; next cycle out_valid = 1, out_dst = 2, out_data = 2A.
- Zero flag update:
  - stimulus: accept res_data=0, res_zf=1, then res_data=5, res_zf=0.
  - required: flag_zero_q = 1 after the first edge, 0 after the second.
- Backpressure:
  - stimulus: out_ready=0, three consecutive res_valid results 1, 2, 3.
  - required: first two accepted; res_ready = 0 after the second; third held with retire_cnt = 2.
  - then out_ready=1: outputs drain in order 1, 2, then 3 is accepted.
- Flush:
  - stimulus: FIFO holding 2 entries, pulse flush with res_valid=1.
  - required: res_ready = 0 that cycle; out_valid = 0 next cycle; regs and retire_cnt unchanged; the held result is accepted after flush deasserts.
- Counter wrap and async reset:
  - stimulus: 256 accepts.
  - required: retire_cnt returns to 0.
  - stimulus: assert reset mid-cycle while out_valid = 1.
  - required: out_valid and all regs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu6_pkg.sv
// Shared definitions for the 6-bit CPU datapath: widths, ALU opcodes and the
// writeback entry layout.
package cpu6_pkg;

  localparam int unsigned DATA_W = 6;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned REG_N  = 4;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_NOT  = 3'd5,
    OP_SHL  = 3'd6,
    OP_SHR  = 3'd7
  } opcode_e;

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_out_fifo.sv
// Two-entry synchronous FIFO (no fall-through) with occupancy count,
// synchronous flush and asynchronous reset.
module wb_out_fifo
  import cpu6_pkg::*;
#(
  parameter type entry_t = wb_entry_t
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       push_i,
  input  entry_t     push_entry_i,
  input  logic       pop_i,
  output logic [1:0] count_o,
  output logic       valid_o,
  output entry_t     head_o
);

  entry_t     mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       do_push;
  logic       do_pop;

  assign do_push = push_i & (count_q != 2'd2);
  assign do_pop  = pop_i & (count_q != 2'd0);

  always_comb begin
    count_d = count_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign valid_o = (count_q != 2'd0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: register file with write forwarding, zero flag,
// retire counter and a tagged result stream through a 2-entry output FIFO.
module alu_writeback #(
  parameter int unsigned DATA_W = cpu6_pkg::DATA_W,
  parameter int unsigned REG_N  = cpu6_pkg::REG_N,
  parameter int unsigned ADDR_W = cpu6_pkg::ADDR_W,
  parameter int unsigned CNT_W  = cpu6_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_zf,
  input  logic [ADDR_W-1:0] res_dst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              flag_zero_q,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_dst,
  output logic [DATA_W-1:0] out_data
);
  import cpu6_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [DATA_W-1:0] regs_q [REG_N];
  logic [CNT_W-1:0]  retire_cnt_q;
  logic [CNT_W-1:0]  retire_cnt_d;
  logic              accept;
  logic [1:0]        fifo_count;
  entry_t            push_entry;
  entry_t            head_entry;

  // Ready depends only on registered occupancy and flush, never on out_ready.
  assign res_ready    = ~flush & (fifo_count != 2'd2);
  assign accept       = res_valid & res_ready;
  assign retire_cnt_d = retire_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < REG_N; i++) regs_q[i] <= '0;
      flag_zero_q  <= 1'b0;
      retire_cnt_q <= '0;
    end else if (accept) begin
      regs_q[res_dst] <= res_data;
      flag_zero_q     <= res_zf;
      retire_cnt_q    <= retire_cnt_d;
    end
  end

  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_data_b = regs_q[rd_addr_b];
    if (accept && (rd_addr_a == res_dst)) rd_data_a = res_data;
    if (accept && (rd_addr_b == res_dst)) rd_data_b = res_data;
  end

  assign push_entry = '{dst: res_dst, data: res_data};

  wb_out_fifo #(
    .entry_t (entry_t)
  ) u_out_fifo (
    .clk_i        (clk),
    .rst_i        (reset),
    .flush_i      (flush),
    .push_i       (accept),
    .push_entry_i (push_entry),
    .pop_i        (out_ready),
    .count_o      (fifo_count),
    .valid_o      (out_valid),
    .head_o       (head_entry)
  );

  assign retire_cnt = retire_cnt_q;
  assign out_dst    = head_entry.dst;
  assign out_data   = head_entry.data;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus a random
// phase, all compared against a queue-based behavioural model.
module tb_alu_writeback;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       res_valid = 1'b0;
  logic       res_ready;
  logic [5:0] res_data = '0;
  logic       res_zf = 1'b0;
  logic [1:0] res_dst = '0;
  logic       flush = 1'b0;
  logic [1:0] rd_addr_a = '0;
  logic [5:0] rd_data_a;
  logic [1:0] rd_addr_b = '0;
  logic [5:0] rd_data_b;
  logic       flag_zero_q;
  logic [7:0] retire_cnt;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_dst;
  logic [5:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: architectural state plus the FIFO as a queue of {dst,data}.
  logic [5:0] m_regs [4];
  logic       m_flag;
  int         m_cnt;
  logic [7:0] m_q [$];

  alu_writeback #(
    .DATA_W (6),
    .REG_N  (4),
    .ADDR_W (2),
    .CNT_W  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_zf      (res_zf),
    .res_dst     (res_dst),
    .flush       (flush),
    .rd_addr_a   (rd_addr_a),
    .rd_data_a   (rd_data_a),
    .rd_addr_b   (rd_addr_b),
    .rd_data_b   (rd_data_b),
    .flag_zero_q (flag_zero_q),
    .retire_cnt  (retire_cnt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_dst     (out_dst),
    .out_data    (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_flag = 1'b0;
    m_cnt  = 0;
    m_q.delete();
  endtask

  // Called just after a falling edge with inputs already applied: checks the
  // cycle's outputs, then advances the model across the rising edge.
  task automatic step();
    logic       exp_ready;
    logic       acc;
    logic [5:0] ea;
    logic [5:0] eb;
    logic [7:0] head;
    exp_ready = !flush && (m_q.size() < 2);
    acc = res_valid && exp_ready;
    ea = (acc && rd_addr_a == res_dst) ? res_data : m_regs[rd_addr_a];
    eb = (acc && rd_addr_b == res_dst) ? res_data : m_regs[rd_addr_b];
    #1;
    check("res_ready", 32'(res_ready), 32'(exp_ready));
    check("rd_data_a", 32'(rd_data_a), 32'(ea));
    check("rd_data_b", 32'(rd_data_b), 32'(eb));
    check("flag_zero", 32'(flag_zero_q), 32'(m_flag));
    check("retire_cnt", 32'(retire_cnt), 32'(m_cnt % 256));
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      head = m_q[0];
      check("out_dst", 32'(out_dst), 32'(head[7:6]));
      check("out_data", 32'(out_data), 32'(head[5:0]));
    end
    @(posedge clk);
    if (flush) begin
      m_q.delete();
    end else begin
      if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
      if (acc) m_q.push_back({res_dst, res_data});
    end
    if (acc) begin
      m_regs[res_dst] = res_data;
      m_flag = res_zf;
      m_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] dst, input logic [5:0] data, input logic zf);
    res_valid = v;
    res_dst   = dst;
    res_data  = data;
    res_zf    = zf;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 2'd0, 6'd0, 1'b0);
    flush = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset then idle
    for (int a = 0; a < 4; a++) begin
      rd_addr_a = 2'(a);
      rd_addr_b = 2'(3 - a);
      step();
    end

    // Single write with forwarding, then drain
    out_ready = 1'b1;
    rd_addr_a = 2'd2;
    drive(1'b1, 2'd2, 6'h2A, 1'b0);
    #1;
    check("fwd_2A", 32'(rd_data_a), 32'h2A);
    step();
    drive(1'b0, 2'd0, 6'd0, 1'b0);
    #1;
    check("regs2_2A", 32'(rd_data_a), 32'h2A);
    check("cnt_1", 32'(retire_cnt), 32'd1);
    check("ov_lat1", 32'(out_valid), 32'd1);
    check("od_2A", 32'(out_data), 32'h2A);
    step();
    step();

    // Zero flag update
    drive(1'b1, 2'd1, 6'd0, 1'b1);
    step();
    check("zf_set", 32'(flag_zero_q), 32'd1);
    drive(1'b1, 2'd3, 6'd5, 1'b0);
    step();
    check("zf_clr", 32'(flag_zero_q), 32'd0);
    drive(1'b0, 2'd0, 6'd0, 1'b0);
    step();
    step();

    // Backpressure: third result held until the FIFO drains
    out_ready = 1'b0;
    drive(1'b1, 2'd1, 6'd1, 1'b0);
    step();
    drive(1'b1, 2'd1, 6'd2, 1'b0);
    step();
    drive(1'b1, 2'd1, 6'd3, 1'b0);
    step();
    step();
    check("bp_cnt", 32'(retire_cnt), 32'(m_cnt % 256));
    check("bp_ready", 32'(res_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (m_q.size() < 2 && res_valid) begin
        step();
        drive(1'b0, 2'd0, 6'd0, 1'b0);
      end else begin
        step();
      end
    end

    // Flush with a result pending
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 6'h11, 1'b0);
    step();
    drive(1'b1, 2'd3, 6'h22, 1'b1);
    step();
    drive(1'b1, 2'd2, 6'h33, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check("fl_ov0", 32'(out_valid), 32'd0);
    step();
    drive(1'b0, 2'd0, 6'd0, 1'b0);
    out_ready = 1'b1;
    step();
    step();

    // Counter wrap after exactly 256 accepts
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), 6'($urandom_range(1, 63)), 1'b0);
      step();
    end
    drive(1'b0, 2'd0, 6'd0, 1'b0);
    #1;
    check("cnt_wrap", 32'(retire_cnt), 32'd0);
    check("wrap_ov", 32'(out_valid), 32'd1);

    // Asynchronous reset mid-cycle with an accept in flight
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 2'd1, 6'h3F, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    drive(1'b0, 2'd0, 6'd0, 1'b0);
    #1;
    check("ar_ov", 32'(out_valid), 32'd0);
    check("ar_od", 32'(out_data), 32'd0);
    check("ar_cnt", 32'(retire_cnt), 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd_addr_a = 2'(a);
      #1;
      check("ar_reg", 32'(rd_data_a), 32'd0);
    end
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rd_addr_a = 2'($urandom_range(0, 3));
      rd_addr_b = 2'($urandom_range(0, 3));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
